// File: rtl/si_pkg.sv
// Shared types and frame-format constants for the serial-interface frame link.
package si_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    DRAIN,
    DONE
  } rx_state_e;

  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

  // S2 upload path into RB2
  localparam int unsigned UP_ADDR_W     = 3;
  localparam int unsigned UP_DATA_W     = 18;
  localparam int unsigned UP_DEPTH      = 8;
  localparam int unsigned UP_NUM_FRAMES = 8;

  // S1 download path into RB1
  localparam int unsigned DN_ADDR_W     = 5;
  localparam int unsigned DN_DATA_W     = 8;
  localparam int unsigned DN_DEPTH      = 18;
  localparam int unsigned DN_NUM_FRAMES = 18;

endpackage

// File: rtl/si_deser.sv
// MSB-first shift register with bit counter; full flags that the next shifted
// bit completes the frame, and frame presents that completed word combinationally.
module si_deser #(
  parameter int unsigned FRAME_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               sd,
  output logic [FRAME_W-1:0] frame,
  output logic               full
);

  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);

  logic [FRAME_W-2:0] r_sr;
  logic [CNT_W-1:0]   r_cnt;

  // Only FRAME_W-1 bits are stored; the final bit is taken straight from sd.
  assign frame = {r_sr, sd};
  assign full  = (r_cnt == CNT_W'(FRAME_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (shift_en) begin
      r_sr  <= frame[FRAME_W-2:0];
      r_cnt <= (clear ? '0 : r_cnt) + CNT_W'(1);
    end else if (clear) begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/si_frame_rx.sv
// Receive end of the sen/sd frame link: deserializes addr+data frames into
// single-cycle buffer writes and flags done after NUM_FRAMES good writes.
module si_frame_rx
  import si_pkg::*;
#(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              frame_err,
  output logic              done
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned FCNT_W  = $clog2(NUM_FRAMES + 1);

  rx_state_e          r_state, w_next;
  logic               w_shift, w_clear, w_full, w_frame_end, w_err;
  logic               w_addr_ok, w_last_write;
  logic [FRAME_W-1:0] w_frame;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  logic               r_mem_rw, r_frame_err, r_done;
  logic [ADDR_W-1:0]  r_mem_a;
  logic [DATA_W-1:0]  r_mem_d;
  logic [FCNT_W-1:0]  r_fcnt;

  si_deser #(.FRAME_W(FRAME_W)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_shift),
    .clear    (w_clear),
    .sd       (sd),
    .frame    (w_frame),
    .full     (w_full)
  );

  assign w_addr       = w_frame[FRAME_W-1 -: ADDR_W];
  assign w_data       = w_frame[DATA_W-1:0];
  assign w_addr_ok    = (32'(w_addr) < DEPTH);
  assign w_last_write = !r_mem_rw && (r_fcnt == FCNT_W'(NUM_FRAMES - 1));

  always_comb begin
    w_next      = r_state;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_frame_end = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!sen) begin
          w_shift = 1'b1;
          w_clear = 1'b1;
          w_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (!sen) begin
          w_shift = 1'b1;
          if (w_full) begin
            w_frame_end = 1'b1;
            w_next      = GAP;
          end
        end else begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      GAP: begin
        if (sen) begin
          w_next = IDLE;
        end else begin
          w_err  = 1'b1;
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (sen) w_next = IDLE;
      end
      DONE: ;
      default: w_next = IDLE;
    endcase
    // The final strobe is still in flight here, so completion overrides GAP handling.
    if (w_last_write) w_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_rw    <= 1'b1;
      r_mem_a     <= '0;
      r_mem_d     <= '0;
      r_frame_err <= 1'b0;
      r_done      <= 1'b0;
      r_fcnt      <= '0;
    end else begin
      r_mem_rw    <= !(w_frame_end && w_addr_ok);
      r_frame_err <= w_err || (w_frame_end && !w_addr_ok);
      if (w_frame_end && w_addr_ok) begin
        r_mem_a <= w_addr;
        r_mem_d <= w_data;
      end
      if (!r_mem_rw) r_fcnt <= r_fcnt + FCNT_W'(1);
      if (w_last_write) r_done <= 1'b1;
    end
  end

  assign mem_rw    = r_mem_rw;
  assign mem_a     = r_mem_a;
  assign mem_d     = r_mem_d;
  assign frame_err = r_frame_err;
  assign done      = r_done;

endmodule

// File: tb/tb_si_frame_rx.sv
// Directed bench for si_frame_rx: upload (3/18/8/8) and download (5/8/18/18) instances.
module tb_si_frame_rx;
  import si_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic up_sen, up_sd, dn_sen, dn_sd;

  logic        up_mem_rw, up_frame_err, up_done;
  logic [2:0]  up_mem_a;
  logic [17:0] up_mem_d;
  logic        dn_mem_rw, dn_frame_err, dn_done;
  logic [4:0]  dn_mem_a;
  logic [7:0]  dn_mem_d;

  always #5 clk = ~clk;

  si_frame_rx u_up (
    .clk       (clk),
    .rst       (rst),
    .sen       (up_sen),
    .sd        (up_sd),
    .mem_rw    (up_mem_rw),
    .mem_a     (up_mem_a),
    .mem_d     (up_mem_d),
    .frame_err (up_frame_err),
    .done      (up_done)
  );

  si_frame_rx #(
    .ADDR_W     (DN_ADDR_W),
    .DATA_W     (DN_DATA_W),
    .DEPTH      (DN_DEPTH),
    .NUM_FRAMES (DN_NUM_FRAMES)
  ) u_dn (
    .clk       (clk),
    .rst       (rst),
    .sen       (dn_sen),
    .sd        (dn_sd),
    .mem_rw    (dn_mem_rw),
    .mem_a     (dn_mem_a),
    .mem_d     (dn_mem_d),
    .frame_err (dn_frame_err),
    .done      (dn_done)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Event monitor: counts strobe cycles and error cycles, keeps last written word.
  int          up_strb = 0, up_errs = 0, dn_strb = 0, dn_errs = 0;
  logic [2:0]  up_last_a;
  logic [17:0] up_last_d;
  logic [4:0]  dn_last_a;
  logic [7:0]  dn_last_d;

  always @(negedge clk) begin
    if (up_mem_rw === 1'b0) begin
      up_strb++;
      up_last_a = up_mem_a;
      up_last_d = up_mem_d;
    end
    if (up_frame_err === 1'b1) up_errs++;
    if (dn_mem_rw === 1'b0) begin
      dn_strb++;
      dn_last_a = dn_mem_a;
      dn_last_d = dn_mem_d;
    end
    if (dn_frame_err === 1'b1) dn_errs++;
  end

  typedef struct {
    bit          dn;
    logic [4:0]  a;
    logic [17:0] d;
    int          len;
    int          exp_strb;
    int          exp_err;
    bit          exp_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit dn, input logic [4:0] a, input logic [17:0] d,
                              input int len, input int es, input int ee, input bit ed);
    vec_t v;
    v.dn = dn; v.a = a; v.d = d; v.len = len;
    v.exp_strb = es; v.exp_err = ee; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit dn, input logic s, input logic b);
    if (dn) begin dn_sen = s; dn_sd = b; end
    else    begin up_sen = s; up_sd = b; end
  endtask

  // Returns on the negedge right after the edge that samples the last bit.
  task automatic send_frame(input bit dn, input logic [4:0] a, input logic [17:0] d, input int len);
    logic [20:0] w;
    int fw;
    if (dn) begin w = {8'b0, a, d[7:0]}; fw = 13; end
    else    begin w = {a[2:0], d};       fw = 21; end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      drive(dn, 1'b0, (i < fw) ? w[fw-1-i] : 1'b1);
    end
    @(negedge clk);
    drive(dn, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_up(input string tag);
    chk({tag, "_up_rw"},   up_mem_rw,    1);
    chk({tag, "_up_a"},    up_mem_a,     0);
    chk({tag, "_up_d"},    up_mem_d,     0);
    chk({tag, "_up_err"},  up_frame_err, 0);
    chk({tag, "_up_done"}, up_done,      0);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t v;
      int s0, e0, ds, de;
      v = tbl[i];
      @(posedge clk);
      s0 = v.dn ? dn_strb : up_strb;
      e0 = v.dn ? dn_errs : up_errs;
      send_frame(v.dn, v.a, v.d, v.len);
      repeat (4) @(negedge clk);
      ds = (v.dn ? dn_strb : up_strb) - s0;
      de = (v.dn ? dn_errs : up_errs) - e0;
      chk($sformatf("v%0d_strobes", i), ds, v.exp_strb);
      chk($sformatf("v%0d_errs", i), de, v.exp_err);
      if (v.exp_strb != 0) begin
        if (v.dn) begin
          chk($sformatf("v%0d_addr", i), dn_last_a, v.a);
          chk($sformatf("v%0d_data", i), dn_last_d, v.d[7:0]);
        end else begin
          chk($sformatf("v%0d_addr", i), up_last_a, v.a[2:0]);
          chk($sformatf("v%0d_data", i), up_last_d, v.d);
        end
      end
      chk($sformatf("v%0d_done", i), v.dn ? dn_done : up_done, v.exp_done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [20:0] part;
    rst = 1'b1;
    up_sen = 1'b1; up_sd = 1'b0;
    dn_sen = 1'b1; dn_sd = 1'b0;

    // 0..3: short frame, good frame, overrun (23 bits), recovery
    tbl.push_back(mk(0, 5'd0, 18'h00000, 12, 0, 1, 0));
    tbl.push_back(mk(0, 5'd2, 18'h12345, 21, 1, 0, 0));
    tbl.push_back(mk(0, 5'd6, 18'h3FFFF, 23, 1, 1, 0));
    tbl.push_back(mk(0, 5'd1, 18'h0ABCD, 21, 1, 0, 0));
    // 4: fresh frame after mid-frame reset
    tbl.push_back(mk(0, 5'd3, 18'h15555, 21, 1, 0, 0));
    // 5..11: frames 0..6 of the eight-frame run
    for (int n = 0; n < 7; n++)
      tbl.push_back(mk(0, 5'(n), 18'h00001 << n, 21, 1, 0, 0));
    // 12: frame after done is ignored
    tbl.push_back(mk(0, 5'd4, 18'h00003, 21, 0, 0, 1));
    // 13..30: download instance, 18 legal frames
    for (int n = 0; n < 18; n++)
      tbl.push_back(mk(1, 5'(n), 18'(8'(n * 13 + 5)), 13, 1, 0, n == 17));

    repeat (2) @(negedge clk);
    chk_reset_up("rst0");
    chk("rst0_dn_rw",   dn_mem_rw,    1);
    chk("rst0_dn_a",    dn_mem_a,     0);
    chk("rst0_dn_err",  dn_frame_err, 0);
    chk("rst0_dn_done", dn_done,      0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame with exact strobe timing
    send_frame(0, 5'd5, 18'h2A5C3, 21);
    chk("single_rw",   up_mem_rw,    0);
    chk("single_a",    up_mem_a,     5);
    chk("single_d",    up_mem_d,     18'h2A5C3);
    chk("single_err",  up_frame_err, 0);
    chk("single_done", up_done,      0);
    @(negedge clk);
    chk("single_rw_end", up_mem_rw, 1);
    @(negedge clk);

    apply_range(0, 3);

    // Reset pulsed together with bit 10 of a frame
    part = {3'd5, 18'h3C3C3};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      up_sen = 1'b0; up_sd = part[20-i];
    end
    @(negedge clk);
    up_sen = 1'b0; up_sd = part[11]; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; up_sen = 1'b1;
    chk_reset_up("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_strobe", up_mem_rw, 1);

    apply_range(4, 4);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    apply_range(5, 11);

    // Eighth frame: strobe, then done on the following cycle
    send_frame(0, 5'd7, 18'h00080, 21);
    chk("f8_rw",   up_mem_rw, 0);
    chk("f8_a",    up_mem_a,  7);
    chk("f8_d",    up_mem_d,  18'h00080);
    chk("f8_done", up_done,   0);
    @(negedge clk);
    chk("f8_done_next", up_done,   1);
    chk("f8_rw_end",    up_mem_rw, 1);
    repeat (2) @(negedge clk);

    apply_range(12, 12);

    // Download instance: illegal address flags error where the write would be
    send_frame(1, 5'd20, 18'h0005A, 13);
    chk("illegal_err", dn_frame_err, 1);
    chk("illegal_rw",  dn_mem_rw,    1);
    chk("illegal_a",   dn_mem_a,     0);
    @(negedge clk);
    chk("illegal_err_end", dn_frame_err, 0);
    @(negedge clk);

    apply_range(13, 30);

    repeat (5) @(negedge clk);
    chk("dn_done_sticky", dn_done, 1);
    chk("up_done_sticky", up_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
